smul_issue_ctrl: RTL
====================

Name: smul_issue_ctrl

Overview:
- Shares one external pipelined unsigned 16x16 multiplier and one 32/16-bit two's-complement converter stage between NREQ requesters of signed multiplies.
- Arbitrates round-robin and strips operand signs into magnitudes.
- Carries sign/width/requester-id tags alongside the fixed-latency multiplier pipeline, then drives the converter with the matching sign bits.
- Registers the signed result with its requester id. Sits between the systolic-array PE request ports and the shared multiply datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width, equal to ceil(log2(NREQ)).
- MUL_LAT, 3, fixed latency in cycles of the external multiplier from mul_valid to mul_p (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  issue enable; 0 blocks new grants, in-flight work drains.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i]&req_ready[i].
- req_width  in  NREQ  per-requester mode: 0 = one 16x16 -> 32-bit product, 1 = two 8x8 -> 16-bit lanes.
- req_a  in  16*NREQ  signed operand A, requester i at [16i+15:16i].
- req_b  in  16*NREQ  signed operand B, same packing.
- mul_valid  out  1  issue strobe to the multiplier.
- mul_width  out  1  mode to the multiplier; 1 = split lanes, no cross-lane partial products.
- mul_a  out  16  magnitude of A.
- mul_b  out  16  magnitude of B.
- mul_p  in  32  unsigned product, valid exactly MUL_LAT cycles after mul_valid.
- conv_width  out  1  converter width select: 0 = 32-bit, 1 = 16-bit lanes.
- conv_sign  out  2  converter complement bits: [1] = high lane/whole word, [0] = low lane.
- conv_in  out  32  converter data input; equals mul_p.
- conv_out  in  32  converter result, combinational from conv_*.
- res_valid  out  1  result strobe, one cycle, no backpressure.
- res_id  out  IDW  requester id of the result.
- res_data  out  32  signed product.
- busy  out  1  any transaction in the issue register or tag pipe.

Behaviour:
- Reset: req_ready=0, mul_valid=0, mul_width=0, mul_a=0, mul_b=0, res_valid=0, res_id=0, res_data=0, busy=0. The round-robin pointer points at requester 0 and the tag pipe is cleared.
- Reset mid-operation: all in-flight tags are discarded. mul_p returning after reset is ignored and produces no res_valid.

Arbitration (combinational):
- With en=1, grant the first requester with req_valid=1, searching from the pointer upward with wrap-around. req_ready is that one-hot grant; it is all zeros if en=0 or no request is pending.
- After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- At most one grant per cycle. Throughput is one transaction per cycle.

Issue stage (registered, cycle T+1 after accept at T):
- mul_valid=1 for exactly one cycle per accepted request.
- width=0:
  - mul_a = |a[15:0]| and mul_b = |b[15:0]| as 16-bit unsigned; -32768 maps to 0x8000.
  - sign = {a[15]^b[15], 1'b0}.
- width=1:
  - mul_a = {|a[15:8]|, |a[7:0]|}, each 8-bit unsigned (-128 maps to 0x80); mul_b likewise.
  - sign = {a[15]^b[15], a[7]^b[7]}.
- Zero operands need no special case: complementing 0 yields 0 in the converter.

Tag pipe:
- Shift register of depth MUL_LAT carrying {valid, id, width, sign[1:0]}, loaded at issue.
- Alignment: the tag exiting at cycle T+1+MUL_LAT coincides with mul_p.

Convert/output stage:
- In the exit cycle, conv_in=mul_p, conv_width=tag.width, conv_sign=tag.sign.
- When the exiting tag valid=0, conv_sign=0 and conv_width=0.
- At the next edge, res_valid=tag.valid, res_id=tag.id, and res_data=conv_out when valid (held otherwise).
- Latency from accept to res_valid is MUL_LAT+2 cycles. Results return in grant order.

Other rules:
- busy=1 whenever the issue register or any tag-pipe stage is valid.
- en deassert mid-stream: no new grants; all accepted transactions still complete.
- Simultaneous requests from all NREQ with en held high: grants rotate 0,1,2,3,0,... with no requester starved; each gets one grant per NREQ cycles.

Test Plan:
- Width-0 signed multiply: req 0 only, a=0xFFFD (-3), b=0x0005, width=0. Required: mul_a=3, mul_b=5, conv_sign=2'b10. With the model returning 15, res_data=0xFFFFFFF1, res_id=0, latency MUL_LAT+2.
- Width-1 split lanes: a=0xFD04, b=0x05FE, width=1. Required: mul_a=0x0304, mul_b=0x0502, conv_sign=2'b11. With the model returning 0x000F0008, res_data=0xFFF1FFF8.
- Extreme operands: a=b=0x8000 with width=0 gives mul_a=mul_b=0x8000 and res_data=0x40000000. a=b=0x8080 with width=1 gives res_data=0x40004000.
- Round-robin fairness: all 4 req_valid held high for 8 cycles. Required: grant sequence 0,1,2,3,0,1,2,3. Results then appear with res_id in that order, back-to-back, with no gaps.
- en and reset: deassert en after 2 grants; req_ready stays 0, both results still emerge and busy falls after the last one. Separately, assert rst one cycle after a grant; no res_valid may follow, and the pointer returns to 0.

Source files
------------

// File: rtl/smul_issue_ctrl.sv
// Round-robin issue controller for a shared unsigned 16x16 multiplier and a
// two's-complement converter; carries sign/width/id tags alongside the multiplier pipe.
module smul_issue_ctrl #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_width,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 mul_valid,
    output logic                 mul_width,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_p,
    output logic                 conv_width,
    output logic [1:0]           conv_sign,
    output logic [31:0]          conv_in,
    input  logic [31:0]          conv_out,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [31:0]          res_data,
    output logic                 busy
);

    function automatic logic [15:0] abs16(input logic [15:0] x);
        return x[15] ? (~x + 16'd1) : x;
    endfunction

    function automatic logic [7:0] abs8(input logic [7:0] x);
        return x[7] ? (~x + 8'd1) : x;
    endfunction

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           grant_any;
    logic [IDW-1:0] grant_id;
    int             idx;

    logic [15:0]    sel_a, sel_b;
    logic           sel_w;
    logic [15:0]    mag_a, mag_b;
    logic [1:0]     sel_sign;

    logic           iss_valid_q;
    logic [IDW-1:0] iss_id_q;
    logic           iss_width_q;
    logic [1:0]     iss_sign_q;
    logic [15:0]    mul_a_q, mul_b_q;

    logic [MUL_LAT-1:0] tag_valid_q;
    logic [IDW-1:0]     tag_id_q    [MUL_LAT];
    logic               tag_width_q [MUL_LAT];
    logic [1:0]         tag_sign_q  [MUL_LAT];

    logic           exit_valid;
    logic           res_valid_q;
    logic [IDW-1:0] res_id_q;
    logic [31:0]    res_data_q;

    // Search upward from the pointer with wrap-around; first pending requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(ptr_q) + k) % int'(NREQ);
            if (!grant_any && en && !rst && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (int'(grant_id) == int'(NREQ) - 1) ? '0 : grant_id + IDW'(1);
        end
    end

    always_comb begin
        sel_a = req_a[16*grant_id +: 16];
        sel_b = req_b[16*grant_id +: 16];
        sel_w = req_width[grant_id];
        if (sel_w) begin
            mag_a    = {abs8(sel_a[15:8]), abs8(sel_a[7:0])};
            mag_b    = {abs8(sel_b[15:8]), abs8(sel_b[7:0])};
            sel_sign = {sel_a[15] ^ sel_b[15], sel_a[7] ^ sel_b[7]};
        end else begin
            mag_a    = abs16(sel_a);
            mag_b    = abs16(sel_b);
            sel_sign = {sel_a[15] ^ sel_b[15], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_id_q    <= '0;
            iss_width_q <= 1'b0;
            iss_sign_q  <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            iss_valid_q <= grant_any;
            if (grant_any) begin
                iss_id_q    <= grant_id;
                iss_width_q <= sel_w;
                iss_sign_q  <= sel_sign;
                mul_a_q     <= mag_a;
                mul_b_q     <= mag_b;
            end
        end
    end

    // Tag pipe: stage MUL_LAT-1 lines up with mul_p for the same transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            for (int k = 0; k < int'(MUL_LAT); k++) begin
                tag_id_q[k]    <= '0;
                tag_width_q[k] <= 1'b0;
                tag_sign_q[k]  <= '0;
            end
        end else begin
            tag_valid_q[0] <= iss_valid_q;
            tag_id_q[0]    <= iss_id_q;
            tag_width_q[0] <= iss_width_q;
            tag_sign_q[0]  <= iss_sign_q;
            for (int k = 1; k < int'(MUL_LAT); k++) begin
                tag_valid_q[k] <= tag_valid_q[k-1];
                tag_id_q[k]    <= tag_id_q[k-1];
                tag_width_q[k] <= tag_width_q[k-1];
                tag_sign_q[k]  <= tag_sign_q[k-1];
            end
        end
    end

    assign exit_valid = tag_valid_q[MUL_LAT-1];

    always_comb begin
        conv_in    = mul_p;
        conv_width = 1'b0;
        conv_sign  = 2'b00;
        if (exit_valid) begin
            conv_width = tag_width_q[MUL_LAT-1];
            conv_sign  = tag_sign_q[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= exit_valid;
            if (exit_valid) begin
                res_id_q   <= tag_id_q[MUL_LAT-1];
                res_data_q <= conv_out;
            end
        end
    end

    assign mul_valid = iss_valid_q;
    assign mul_width = iss_width_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign busy      = iss_valid_q | (|tag_valid_q);

endmodule
